// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bus between the program-sequencing stage and whoever drives it.
//   master: loads the store (LoadEn/LoadAddr/LoadData), controls execution
//           (Start/Stop) and observes Instruction, PC, Running, Halted, Count.
//   slave : the instr_fetch stage itself.
interface instr_fetch_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned IW = 9
);
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [IW-1:0] LoadData;
    logic          Start;
    logic          Stop;
    logic [IW-1:0] Instruction;
    logic [AW-1:0] PC;
    logic          Running;
    logic          Halted;
    logic [7:0]    Count;

    modport master (
        output LoadEn, LoadAddr, LoadData, Start, Stop,
        input  Instruction, PC, Running, Halted, Count
    );

    modport slave (
        input  LoadEn, LoadAddr, LoadData, Start, Stop,
        output Instruction, PC, Running, Halted, Count
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program store plus program counter feeding cpu.Instruction.
//   CLK   : system clock, all state changes on posedge.
//   Reset : asynchronous, active-high; returns to IDLE with a bubble on the bus.
//   bus   : instr_fetch_if.slave
//           LoadEn/LoadAddr/LoadData write the store while not running.
//           Start begins execution at address 0; Stop halts a running program.
//           Instruction is registered; PC is the next fetch address;
//           Running/Halted decode the state; Count is a saturating issue count.
module instr_fetch #(
    parameter int unsigned    DEPTH  = 16,
    parameter int unsigned    AW     = 4,
    parameter int unsigned    IW     = 9,
    parameter logic [IW-1:0]  BUBBLE = 9'b101_0000_00
) (
    input  logic              CLK,
    input  logic              Reset,
    instr_fetch_if.slave      bus
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    count_q, count_d;
    logic [IW-1:0] instr_q, instr_d;

    // Deliberately not reset: a program survives Reset.
    logic [IW-1:0] mem [DEPTH];

    logic [IW-1:0] word;
    logic          is_halt;

    assign word    = mem[pc_q];
    assign is_halt = (word[IW-1 -: 3] == 3'b111);

    always_ff @(posedge CLK) begin
        if (bus.LoadEn && (state_q != StRun)) begin
            mem[bus.LoadAddr] <= bus.LoadData;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        instr_d = instr_q;
        unique case (state_q)
            StIdle, StHalted: begin
                // Start beats a simultaneous Stop; Stop alone is ignored here.
                if (bus.Start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    count_d = '0;
                    instr_d = BUBBLE;
                end
            end
            StRun: begin
                if (bus.Stop || is_halt) begin
                    // HALT words are never issued; PC stays on the stopping address.
                    state_d = StHalted;
                    instr_d = BUBBLE;
                end else begin
                    instr_d = word;
                    pc_d    = pc_q + 1'b1;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                instr_d = BUBBLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            count_q <= '0;
            instr_q <= BUBBLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            instr_q <= instr_d;
        end
    end

    assign bus.Instruction = instr_q;
    assign bus.PC          = pc_q;
    assign bus.Count       = count_q;
    assign bus.Running     = (state_q == StRun);
    assign bus.Halted      = (state_q == StHalted);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [8:0] BUB  = 9'b101_0000_00;
    localparam logic [8:0] FILL = 9'b000_01_10_11;
    localparam logic [8:0] HALT = 9'b111_0000_00;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    instr_fetch_if #(.AW(4), .IW(9)) bus ();

    instr_fetch dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the fetch stage as a tiny interpreter over an array.
    logic [8:0] m_mem [16];
    int         m_pc;
    int         m_count;
    bit         m_run;
    bit         m_halt;
    logic [8:0] m_instr;

    task automatic model_reset();
        m_pc = 0; m_count = 0; m_run = 0; m_halt = 0; m_instr = BUB;
    endtask

    task automatic model_edge(input bit start, input bit stop, input bit le,
                              input int la, input logic [8:0] ld);
        logic [8:0] w;
        if (!m_run) begin
            if (le) m_mem[la] = ld;
            if (start) begin
                m_run = 1; m_halt = 0; m_pc = 0; m_count = 0; m_instr = BUB;
            end
        end else begin
            w = m_mem[m_pc];
            if (stop || w[8:6] == 3'b111) begin
                m_run = 0; m_halt = 1; m_instr = BUB;
            end else begin
                m_instr = w;
                m_pc    = (m_pc + 1) % 16;
                m_count = (m_count < 255) ? m_count + 1 : 255;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr"},   {23'd0, bus.Instruction}, {23'd0, m_instr});
        chk({tag, ".pc"},      {28'd0, bus.PC},          m_pc);
        chk({tag, ".count"},   {24'd0, bus.Count},       m_count);
        chk({tag, ".running"}, {31'd0, bus.Running},     {31'd0, m_run});
        chk({tag, ".halted"},  {31'd0, bus.Halted},      {31'd0, m_halt});
    endtask

    // Drive inputs, take one edge, advance the model, sample 1 ns later.
    task automatic step(input string tag, input bit start, input bit stop, input bit le,
                        input int la, input logic [8:0] ld);
        bus.Start = start; bus.Stop = stop; bus.LoadEn = le;
        bus.LoadAddr = la[3:0]; bus.LoadData = ld;
        @(posedge CLK);
        model_edge(start, stop, le, la, ld);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 9'd0);
    endtask

    task automatic fill_store();
        for (int i = 0; i < 16; i++) step("fill", 0, 0, 1, i, FILL);
    endtask

    initial begin
        logic [8:0] prog [4];
        prog[0] = 9'b101011101; prog[1] = 9'b101010110;
        prog[2] = 9'b001011011; prog[3] = HALT;

        bus.Start = 0; bus.Stop = 0; bus.LoadEn = 0; bus.LoadAddr = '0; bus.LoadData = '0;
        Reset = 1;
        model_reset();
        #1;
        check_all("reset");
        @(negedge CLK);
        Reset = 0;

        // Load and run with halt.
        fill_store();
        for (int i = 0; i < 4; i++) step("load", 0, 0, 1, i, prog[i]);
        step("start", 1, 0, 0, 0, 9'd0);
        chk("start.bubble", {23'd0, bus.Instruction}, {23'd0, BUB});
        for (int i = 0; i < 3; i++) begin
            idle("run");
            chk("run.seq", {23'd0, bus.Instruction}, {23'd0, prog[i]});
        end
        idle("halt");
        idle("halt.hold");
        chk("halt.halted", {31'd0, bus.Halted}, 32'd1);
        chk("halt.pc",     {28'd0, bus.PC},     32'd3);
        chk("halt.count",  {24'd0, bus.Count},  32'd3);
        chk("halt.instr",  {23'd0, bus.Instruction}, {23'd0, BUB});

        // External stop at PC = 5, then restart.
        fill_store();
        step("start2", 1, 0, 0, 0, 9'd0);
        for (int i = 0; i < 5; i++) idle("run2");
        step("stop", 0, 1, 0, 0, 9'd0);
        chk("stop.halted", {31'd0, bus.Halted}, 32'd1);
        chk("stop.pc",     {28'd0, bus.PC},     32'd5);
        chk("stop.count",  {24'd0, bus.Count},  32'd5);
        step("stop.idle", 0, 1, 0, 0, 9'd0);
        step("restart", 1, 0, 0, 0, 9'd0);
        chk("restart.pc",    {28'd0, bus.PC},    32'd0);
        chk("restart.count", {24'd0, bus.Count}, 32'd0);
        idle("restart.first");
        chk("restart.instr", {23'd0, bus.Instruction}, {23'd0, FILL});
        step("restart.startignored", 1, 0, 0, 0, 9'd0);
        step("stop2", 0, 1, 0, 0, 9'd0);

        // Wrap-around over 20 cycles.
        step("start3", 1, 0, 0, 0, 9'd0);
        for (int i = 0; i < 20; i++) idle("wrap");
        chk("wrap.count",   {24'd0, bus.Count},   32'd20);
        chk("wrap.pc",      {28'd0, bus.PC},      32'd4);
        chk("wrap.running", {31'd0, bus.Running}, 32'd1);

        // Load gating: ignored while running, honoured while halted.
        step("gate.run", 0, 0, 1, 2, HALT);
        for (int i = 0; i < 16; i++) idle("gate.pass");
        chk("gate.running", {31'd0, bus.Running}, 32'd1);
        step("gate.stop", 0, 1, 0, 0, 9'd0);
        step("gate.halted", 0, 0, 1, 2, HALT);
        step("gate.start", 1, 0, 0, 0, 9'd0);
        for (int i = 0; i < 3; i++) idle("gate.rerun");
        chk("gate.halted", {31'd0, bus.Halted}, 32'd1);
        chk("gate.pc",     {28'd0, bus.PC},     32'd2);

        // Reset mid-run at PC = 3, between edges.
        step("rst.fix", 0, 0, 1, 2, FILL);
        step("rst.start", 1, 0, 0, 0, 9'd0);
        for (int i = 0; i < 3; i++) idle("rst.run");
        chk("rst.pc3", {28'd0, bus.PC}, 32'd3);
        #3;
        Reset = 1;
        #1;
        chk("rst.instr",   {23'd0, bus.Instruction}, {23'd0, BUB});
        chk("rst.pc",      {28'd0, bus.PC},          32'd0);
        chk("rst.running", {31'd0, bus.Running},     32'd0);
        model_reset();
        @(negedge CLK);
        Reset = 0;

        // Simultaneous Start + LoadEn, then Start + Stop.
        step("sim.startload", 1, 0, 1, 0, 9'b101111101);
        idle("sim.first");
        chk("sim.first", {23'd0, bus.Instruction}, {23'd0, 9'b101111101});
        #3;
        Reset = 1;
        #1;
        model_reset();
        @(negedge CLK);
        Reset = 0;
        step("sim.startstop", 1, 1, 0, 0, 9'd0);
        chk("sim.running", {31'd0, bus.Running}, 32'd1);

        // Randomized traffic against the model.
        step("rnd.stop", 0, 1, 0, 0, 9'd0);
        for (int i = 0; i < 16; i++) step("rnd.load", 0, 0, 1, i, 9'($urandom));
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                 9'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
